// File: rtl/line_buffer_3x3.sv
// -----------------------------------------------------------------------------
// line_buffer_3x3
//
// Purpose:
//   Streaming 3x3 window generator. It takes one raster-order pixel per
//   valid_in cycle and keeps the two previous image rows in line buffers. For
//   every unpadded output position it emits the full 3x3 neighbourhood, one
//   clock after the pixel that completes that neighbourhood. The window order
//   is the in_data0..in_data8 order that conv_3x3 expects.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous, active-high reset
//   valid_in              in_data carries a pixel this cycle
//   in_data               signed pixel, row-major, column 0 first
//   win_data0..win_data8  registered window, win_data[3*i+j] = pixel(r-2+i, c-2+j)
//                         (win_data0 top-left, win_data8 newest pixel)
//   valid_out             win_data0..8 hold a valid window this cycle
//   frame_done            one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module line_buffer_3x3 #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] win_data0,
  output logic signed [DATA_W-1:0] win_data1,
  output logic signed [DATA_W-1:0] win_data2,
  output logic signed [DATA_W-1:0] win_data3,
  output logic signed [DATA_W-1:0] win_data4,
  output logic signed [DATA_W-1:0] win_data5,
  output logic signed [DATA_W-1:0] win_data6,
  output logic signed [DATA_W-1:0] win_data7,
  output logic signed [DATA_W-1:0] win_data8,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  // Raster position of the pixel currently presented on in_data.
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  // r_lb1 holds row r-1 and r_lb2 holds row r-2, both indexed by column.
  logic signed [DATA_W-1:0] r_lb1 [IMG_W];
  logic signed [DATA_W-1:0] r_lb2 [IMG_W];

  // 3x3 shift window, row-major; column 2 of each row is the newest column.
  logic signed [DATA_W-1:0] r_win [9];

  logic r_valid;
  logic r_done;

  logic                     w_col_last;
  logic                     w_row_last;
  logic                     w_win_ok;
  logic signed [DATA_W-1:0] w_top;
  logic signed [DATA_W-1:0] w_mid;

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // Columns 0/1 and rows 0/1 are excluded. This keeps horizontally wrapped
  // columns (from the previous row) and line-buffer contents left over from
  // an earlier frame or from before reset out of every emitted window.
  assign w_win_ok = (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  // Pixels directly above the incoming one: rows r-2 and r-1, same column.
  assign w_top = r_lb2[r_col];
  assign w_mid = r_lb1[r_col];

  // ---------------------------------------------------------------------------
  // Position counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. They have no reset because their contents never reach a
  // valid window before rows 0 and 1 of the frame have overwritten them.
  // Each accepted pixel pushes its column down by one row.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Window shift register and output flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        r_win[k] <= '0;
      end
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= valid_in && w_win_ok;
      r_done  <= valid_in && w_col_last && w_row_last;
      if (valid_in) begin
        // Top row: pixels from row r-2.
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= w_top;
        // Middle row: pixels from row r-1.
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= w_mid;
        // Bottom row: pixels from the current row.
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= in_data;
      end
    end
  end

  assign win_data0  = r_win[0];
  assign win_data1  = r_win[1];
  assign win_data2  = r_win[2];
  assign win_data3  = r_win[3];
  assign win_data4  = r_win[4];
  assign win_data5  = r_win[5];
  assign win_data6  = r_win[6];
  assign win_data7  = r_win[7];
  assign win_data8  = r_win[8];
  assign valid_out  = r_valid;
  assign frame_done = r_done;

endmodule

// File: tb/tb_line_buffer_3x3.sv
// -----------------------------------------------------------------------------
// tb_line_buffer_3x3
//
// Directed bench for line_buffer_3x3 using a 5x4 image with 8-bit pixels.
// Each pixel is driven, and the outputs are sampled 1 time unit after the
// clock edge that accepts it. An image-array reference supplies the expected
// window for each position. Hand-computed constants cover the first window,
// the last window, window counts and frame_done counts.
// -----------------------------------------------------------------------------
module tb_line_buffer_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic signed [DW-1:0] win_data0, win_data1, win_data2, win_data3, win_data4;
  logic signed [DW-1:0] win_data5, win_data6, win_data7, win_data8;
  logic                 valid_out;
  logic                 frame_done;

  line_buffer_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .in_data    (in_data),
    .win_data0  (win_data0),
    .win_data1  (win_data1),
    .win_data2  (win_data2),
    .win_data3  (win_data3),
    .win_data4  (win_data4),
    .win_data5  (win_data5),
    .win_data6  (win_data6),
    .win_data7  (win_data7),
    .win_data8  (win_data8),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] win_arr [9];
  assign win_arr[0] = win_data0;
  assign win_arr[1] = win_data1;
  assign win_arr[2] = win_data2;
  assign win_arr[3] = win_data3;
  assign win_arr[4] = win_data4;
  assign win_arr[5] = win_data5;
  assign win_arr[6] = win_data6;
  assign win_arr[7] = win_data7;
  assign win_arr[8] = win_data8;

  int n_assert = 0;
  int n_fail   = 0;

  int img [H][W];
  int first_win [9];
  int last_win  [9];
  int n_win;
  int n_done;
  int conv_sum;

  int exp_first1 [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int exp_last1  [9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
  int exp_first2 [9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
  int exp_first5 [9] = '{-128, -128, -128, -128, -128, -128, -128, -128, 127};

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int win(input int k);
    return int'(win_arr[k]);
  endfunction

  task automatic send(input int pix);
    valid_in = 1'b1;
    in_data  = DW'(pix);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n, input int held);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk({tag, " gap valid_out"}, int'(valid_out), 0);
      chk({tag, " gap frame_done"}, int'(frame_done), 0);
      chk({tag, " gap win8 hold"}, win(8), held);
    end
  endtask

  task automatic cmp_win(input string tag, input int got [9], input int exp [9]);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = base + W * r + c;
  endtask

  // Sends one whole frame from img. Every output is checked against the
  // image reference, and the first and last windows are captured.
  task automatic run_frame(input string tag, input int gaps);
    int exp_v;
    int exp_d;
    n_win  = 0;
    n_done = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(img[r][c]);
        exp_v = (r >= 2 && c >= 2) ? 1 : 0;
        exp_d = (r == H - 1 && c == W - 1) ? 1 : 0;
        chk($sformatf("%s valid_out r%0d c%0d", tag, r, c), int'(valid_out), exp_v);
        chk($sformatf("%s frame_done r%0d c%0d", tag, r, c), int'(frame_done), exp_d);
        if (exp_v == 1) begin
          for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s win r%0d c%0d k%0d", tag, r, c, k), win(k),
                img[r - 2 + k / 3][c - 2 + k % 3]);
            if (n_win == 0) first_win[k] = win(k);
            last_win[k] = win(k);
          end
        end
        if (valid_out === 1'b1) n_win++;
        if (frame_done === 1'b1) n_done++;
        if (gaps > 0) idle_check(tag, gaps, img[r][c]);
      end
    end
  endtask

  initial begin
    // Reset state, sampled while rst is held.
    #1;
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset frame_done", int'(frame_done), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset win%0d", k), win(k), 0);
    #11;
    rst = 1'b0;

    // Scenario 1: continuous ramp frame.
    fill_ramp(0);
    run_frame("s1", 0);
    chk("s1 window count", n_win, 6);
    chk("s1 frame_done count", n_done, 1);
    cmp_win("s1 first", first_win, exp_first1);
    cmp_win("s1 last", last_win, exp_last1);
    conv_sum = 0;
    for (int k = 0; k < 9; k++) conv_sum += first_win[k];
    chk("s1 conv ones sum", conv_sum, 54);

    // Scenario 2: same image, three idle cycles after every pixel.
    run_frame("s2", 3);
    chk("s2 window count", n_win, 6);
    chk("s2 frame_done count", n_done, 1);
    cmp_win("s2 first", first_win, exp_first1);
    cmp_win("s2 last", last_win, exp_last1);

    // Scenario 3: back-to-back frames, the second one offset by 100.
    run_frame("s3a", 0);
    fill_ramp(100);
    run_frame("s3b", 0);
    chk("s3b window count", n_win, 6);
    chk("s3b frame_done count", n_done, 1);
    cmp_win("s3b first", first_win, exp_first2);

    // Scenario 4: asynchronous reset mid-frame, then a fresh frame.
    fill_ramp(0);
    for (int i = 0; i <= 8; i++) send(i);
    chk("s4 win8 before rst", win(8), 8);
    #1 rst = 1'b1;
    #1;
    chk("s4 async win8", win(8), 0);
    chk("s4 async valid_out", int'(valid_out), 0);
    chk("s4 async frame_done", int'(frame_done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= 12; i++) send(i);
    chk("s4 valid before 2nd rst", int'(valid_out), 1);
    #1 rst = 1'b1;
    #1;
    chk("s4 2nd async valid_out", int'(valid_out), 0);
    chk("s4 2nd async win0", win(0), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame("s4", 0);
    chk("s4 window count", n_win, 6);
    chk("s4 frame_done count", n_done, 1);
    cmp_win("s4 first", first_win, exp_first1);
    cmp_win("s4 last", last_win, exp_last1);

    // Scenario 5: signed extremes.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = -128;
    img[2][2] = 127;
    run_frame("s5", 0);
    chk("s5 window count", n_win, 6);
    chk("s5 frame_done count", n_done, 1);
    cmp_win("s5 first", first_win, exp_first5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_3x3.md
Name: line_buffer_3x3

Overview:
- Streaming window generator that produces the 3x3 pixel neighbourhoods consumed by conv_3x3.
- Accepts one raster-order pixel per valid cycle and stores the two previous image rows in internal line buffers.
- Emits a complete 3x3 window, in the in_data0..in_data8 order conv_3x3 expects, for every valid (unpadded) output position.
- Sits between the feature-map source and conv_3x3; its outputs connect directly to conv_3x3 in_data*/valid_in.

Parameters:
- IMG_W, 28, image width in pixels (>= 3)
- IMG_H, 28, image height in pixels (>= 3)
- DATA_W, 8, pixel width in bits, signed

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  in_data carries a pixel this cycle
- in_data  in  DATA_W  signed pixel, raster order (row-major, col 0 first)
- win_data0..win_data8  out  DATA_W each  signed window pixels, registered
- valid_out  out  1  win_data0..8 hold a valid window this cycle
- frame_done  out  1  one-cycle pulse: last pixel of the frame was accepted

Behaviour:
- Reset values: win_data0..8 = 0, valid_out = 0, frame_done = 0, col = 0, row = 0. Line-buffer contents are don't-care and are not cleared.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on valid_in=1.
  - col wraps to 0 at IMG_W-1 and row increments.
  - At col=IMG_W-1 and row=IMG_H-1 both wrap to 0, so the next pixel starts a new frame. There is no idle gap and no start signal.
- Storage: two line buffers of IMG_W entries each (row r-1 and row r-2), written and read at index col on each accepted pixel, plus a 3x3 register window shifted left by one column per accepted pixel.
- Window mapping for the pixel accepted at (r, c): win_data[3*i+j] = pixel(r-2+i, c-2+j) for i, j in 0..2.
  - win_data0 is top-left; win_data8 is the current pixel.
- valid_out = 1 exactly one cycle after an accepted pixel with row >= 2 and col >= 2; otherwise 0.
  - Latency from pixel to window: 1 clk.
  - Windows per frame: (IMG_W-2)*(IMG_H-2).
- Columns 0 and 1 of each row produce no window. Horizontal wrap never mixes pixels from adjacent rows into a valid window.
- Rows 0 and 1 of each frame produce no window. Stale line-buffer data from a previous frame or from before reset is never emitted.
- valid_in=0 cycles:
  - Counters, line buffers and the window hold their values.
  - valid_out and frame_done are 0 the following cycle.
  - win_data holds its last value.
- No backpressure; the downstream block must accept every valid_out.
- frame_done asserts one cycle after the last pixel (row IMG_H-1, col IMG_W-1) is accepted, coincident with the final valid_out.
- Reset mid-frame:
  - Outputs clear immediately (asynchronous).
  - The first pixel after reset release is treated as (0, 0).
- Data is passed through unchanged: no arithmetic, sign preserved.
- Counter widths are $clog2 of IMG_W and IMG_H.

Test Plan:
- IMG_W=5, IMG_H=4, pixel value = 5*row + col, continuous valid_in.
  - First valid_out comes 1 cycle after pixel 12, with win_data0..8 = 0,1,2,5,6,7,10,11,12.
  - Exactly 6 valid_out pulses in total.
  - Last window = 7,8,9,12,13,14,17,18,19, with frame_done=1 on the same cycle.
- Same image with valid_in deasserted for 3 cycles after every pixel.
  - Identical 6 windows in the same order.
  - valid_out never asserts during gaps.
  - frame_done still pulses once.
- Two back-to-back frames; frame 2 pixel value = 100 + index.
  - Frame 2's first window = 100,101,102,105,106,107,110,111,112, one cycle after its 13th pixel.
  - No frame-1 values appear in any frame-2 window.
- Assert rst for 2 cycles after pixel 8 of a frame.
  - valid_out and frame_done drop to 0 asynchronously.
  - Restarting with a fresh frame reproduces the scenario-1 output exactly.
- Signed extremes: frame filled with -128 except pixel 12 = 127.
  - First window = eight -128 values and win_data8 = 127.
  - The rest of the output sequence continues unchanged.
- Chain into conv_3x3 with all weights = 1, using scenario-1 data.
  - First out_data = 54 (sum 0+1+2+5+6+7+10+11+12).
